// File: rtl/vga_scanout_if.sv
// Frame-buffer read port (port 2) between the scanout engine and video memory.
//   vmem_out_addr : 20-bit byte address, driven by the scanout (master)
//   vmem_out_data : 8-bit RGB332 read data, returned by memory (slave),
//                   valid 2 clk after the address changes
interface vga_scanout_if;
  logic [19:0] vmem_out_addr;
  logic [7:0]  vmem_out_data;

  modport master (output vmem_out_addr, input vmem_out_data);
  modport slave  (input vmem_out_addr, output vmem_out_data);
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout for a 640x240x8 RGB332 frame buffer, shown as 640x480@60 with
// each stored line displayed twice. One pixel slot is 4 clk of the 100 MHz clock.
// Ports:
//   clk, rst      : system clock, synchronous active-low reset
//   en            : scanout enable; low holds the block idle as in reset
//   vmem          : frame-buffer read port (address out, data in)
//   vga_r/g/b     : registered colour (RGB332 split 3/3/2)
//   vga_hs/vga_vs : registered active-low syncs, aligned with colour
//   vblank        : high while the current line is past the visible area
//   frame_start   : one-clk pulse with the outputs of the last pixel of a frame
module vga_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  vga_scanout_if.master        vmem,
  output logic [2:0]           vga_r,
  output logic [2:0]           vga_g,
  output logic [1:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vblank,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VISC  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VISC  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [19:0]   LB_STEP = 20'(H_VIS);

  logic [1:0]    r_div;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [19:0]   r_line_base;
  logic [19:0]   r_addr;
  logic [7:0]    r_rgb;
  logic          r_hs;
  logic          r_vs;
  logic          r_vblank;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_visible;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_vblank;
  logic [HW-1:0] w_hcnt_nxt;
  logic [VW-1:0] w_vcnt_nxt;
  logic [19:0]   w_lb_nxt;
  logic          w_vis_nxt;
  logic [19:0]   w_addr_nxt;

  always_comb begin
    w_tick     = (r_div == 2'd3);
    w_h_wrap   = (r_hcnt == H_LAST);
    w_v_wrap   = (r_vcnt == V_LAST);
    w_visible  = (r_hcnt < H_VISC) && (r_vcnt < V_VISC);
    w_hs_n     = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
    w_vs_n     = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
    w_vblank   = (r_vcnt >= V_VISC);

    w_hcnt_nxt = r_hcnt + HW'(1);
    w_vcnt_nxt = r_vcnt;
    w_lb_nxt   = r_line_base;
    if (w_h_wrap) begin
      w_hcnt_nxt = '0;
      w_vcnt_nxt = w_v_wrap ? '0 : r_vcnt + VW'(1);
      // Base advances only after the second copy of a stored line.
      if (w_v_wrap)
        w_lb_nxt = '0;
      else if (r_vcnt[0] && (r_vcnt < V_VISC))
        w_lb_nxt = r_line_base + LB_STEP;
    end

    // Address register is loaded with the address of the slot being entered,
    // so it is stable for the whole 4-clk slot before data is sampled.
    w_vis_nxt  = (w_hcnt_nxt < H_VISC) && (w_vcnt_nxt < V_VISC);
    w_addr_nxt = w_vis_nxt ? (w_lb_nxt + 20'(w_hcnt_nxt)) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      r_div         <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_line_base   <= '0;
      r_addr        <= '0;
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= r_div + 2'd1;
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_hcnt        <= w_hcnt_nxt;
        r_vcnt        <= w_vcnt_nxt;
        r_line_base   <= w_lb_nxt;
        r_addr        <= w_addr_nxt;
        r_rgb         <= w_visible ? vmem.vmem_out_data : '0;
        r_hs          <= w_hs_n;
        r_vs          <= w_vs_n;
        r_vblank      <= w_vblank;
        r_frame_start <= w_h_wrap && w_v_wrap;
      end
    end
  end

  assign vmem.vmem_out_addr = r_addr;
  assign vga_r       = r_rgb[7:5];
  assign vga_g       = r_rgb[4:2];
  assign vga_b       = r_rgb[1:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vblank      = r_vblank;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-timing instance checked every cycle against
// a slot-arithmetic model with random memory contents and random enable drops,
// plus a full-timing instance checked at hand-computed points.
module tb_vga_scanout;

  localparam int SHV = 8, SHFP = 2, SHS = 3, SHBP = 2;
  localparam int SVV = 6, SVFP = 1, SVS = 2, SVBP = 1;
  localparam int SHT = SHV + SHFP + SHS + SHBP;   // 15
  localparam int SVT = SVV + SVFP + SVS + SVBP;   // 10

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic en   = 1'b0;
  logic en_d = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  vga_scanout_if vif_s ();
  vga_scanout_if vif_d ();

  logic [2:0] s_r, s_g, d_r, d_g;
  logic [1:0] s_b, d_b;
  logic s_hs, s_vs, s_vb, s_fs, d_hs, d_vs, d_vb, d_fs;

  vga_scanout #(
    .H_VIS(SHV), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_VIS(SVV), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .vmem(vif_s),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vblank(s_vb), .frame_start(s_fs)
  );

  vga_scanout u_dflt (
    .clk(clk), .rst(rst), .en(en_d), .vmem(vif_d),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
    .vblank(d_vb), .frame_start(d_fs)
  );

  // Memories with 2-clk read latency. Full-size one holds mem[a] = a[7:0].
  logic [7:0] mem [64];
  logic [7:0] s_d1 = '0, s_d2 = '0, d_d1 = '0, d_d2 = '0;
  always @(posedge clk) begin
    s_d1 <= mem[vif_s.vmem_out_addr[5:0]];
    s_d2 <= s_d1;
    d_d1 <= vif_d.vmem_out_addr[7:0];
    d_d2 <= d_d1;
  end
  assign vif_s.vmem_out_data = s_d2;
  assign vif_d.vmem_out_data = d_d2;

  // Edges elapsed since the block left idle.
  longint n = 0, nd = 0;
  always @(posedge clk) begin
    n  <= (rst && en)   ? n + 1  : 0;
    nd <= (rst && en_d) ? nd + 1 : 0;
  end

  // Address the display needs for a given slot index since enable.
  function automatic logic [19:0] slot_addr(input longint p);
    int h, v;
    h = int'(p % SHT);
    v = int'((p / SHT) % SVT);
    if (h < SHV && v < SVV) return 20'((v / 2) * SHV + h);
    return '0;
  endfunction

  bit meas = 0;
  int hs_lo = 0, vs_lo = 0, vb_hi = 0;
  longint fsq[$];

  always @(negedge clk) begin : compare
    logic [19:0] e_addr, qa;
    logic [7:0]  e_rgb, g_rgb;
    logic        e_hs, e_vs, e_vb, e_fs;
    longint      q;
    int          h, v;
    e_addr = slot_addr(n / 4);
    e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_fs = 1'b0;
    if (n >= 4) begin
      q  = n / 4 - 1;
      h  = int'(q % SHT);
      v  = int'((q / SHT) % SVT);
      qa = slot_addr(q);
      if (h < SHV && v < SVV) e_rgb = mem[qa[5:0]];
      e_hs = !(h >= SHV + SHFP && h < SHV + SHFP + SHS);
      e_vs = !(v >= SVV + SVFP && v < SVV + SVFP + SVS);
      e_vb = (v >= SVV);
      e_fs = (n % 4 == 0) && (h == SHT - 1) && (v == SVT - 1);
    end
    g_rgb = {s_r, s_g, s_b};
    tests++;
    if (g_rgb !== e_rgb || s_hs !== e_hs || s_vs !== e_vs || s_vb !== e_vb ||
        s_fs !== e_fs || vif_s.vmem_out_addr !== e_addr) begin
      fails++;
      $display("FAIL scan n=%0d got/exp rgb=%h/%h hs=%b/%b vs=%b/%b vb=%b/%b fs=%b/%b addr=%0d/%0d",
               n, g_rgb, e_rgb, s_hs, e_hs, s_vs, e_vs, s_vb, e_vb, s_fs, e_fs,
               vif_s.vmem_out_addr, e_addr);
    end
    if (meas && n >= 4 && n <= 1803) begin
      if (!s_hs) hs_lo++;
      if (!s_vs) vs_lo++;
      if (s_vb)  vb_hi++;
      if (s_fs)  fsq.push_back(n);
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Full-timing instance: hand-computed points (edge count, kind, value).
  // kind 0 addr, 1 rgb, 2 hsync, 3 vsync
  bit d_done = 0;
  initial begin : dflt_checks
    longint cn [15] = '{2, 4, 24, 2556, 2560, 2627, 2628, 3011, 3012,
                        3200, 3204, 6400, 6404, 6416, 6416};
    int ck [15] = '{0, 0, 1, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0, 1, 3};
    int cv [15] = '{0, 1, 5, 639, 0, 1, 0, 0, 1, 0, 1, 640, 641, 131, 1};
    longint got;
    for (int i = 0; i < 15; i++) begin
      int guard = 0;
      while (nd != cn[i] && guard < 20000) begin
        @(negedge clk);
        guard++;
      end
      case (ck[i])
        0:       got = vif_d.vmem_out_addr;
        1:       got = {d_r, d_g, d_b};
        2:       got = d_hs;
        default: got = d_vs;
      endcase
      chk($sformatf("full_timing[%0d]@%0d", i, cn[i]), got, cv[i]);
    end
    d_done = 1;
  end

  task automatic fill_mem(input bit all_ff);
    for (int i = 0; i < 64; i++) mem[i] = all_ff ? 8'hFF : 8'($urandom);
  endtask

  // Drop enable for k clk; memory contents change only while idle.
  task automatic drop_en(input int k, input bit all_ff);
    en = 1'b0;
    @(negedge clk);
    fill_mem(all_ff);
    repeat (k - 1) @(negedge clk);
    en = 1'b1;
  endtask

  initial begin : main
    fill_mem(1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    // Free run of three frames on both instances.
    en = 1'b1; en_d = 1'b1; meas = 1;
    repeat (1810) @(negedge clk);
    meas = 0;
    chk("hsync_low_clk_3frames", hs_lo, 360);
    chk("vsync_low_clk_3frames", vs_lo, 360);
    chk("vblank_clk_3frames", vb_hi, 720);
    chk("frame_start_count", fsq.size(), 3);
    if (fsq.size() == 3) begin
      chk("frame_start_0", fsq[0], 600);
      chk("frame_start_1", fsq[1], 1200);
      chk("frame_start_2", fsq[2], 1800);
    end

    // Random enable drops with fresh memory contents.
    for (int i = 0; i < 8; i++) begin
      drop_en(int'($urandom_range(1, 6)), 1'b0);
      repeat ($urandom_range(50, 700)) @(negedge clk);
    end

    // Abort mid-frame at line 3, pixel 5, for 5 clk, then run past a frame.
    drop_en(3, 1'b0);
    begin
      int guard = 0;
      while (n != 4 * (3 * SHT + 5) + 2 && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      chk("abort_point_reached", n, 4 * (3 * SHT + 5) + 2);
    end
    drop_en(5, 1'b0);
    repeat (610) @(negedge clk);

    // All-0xFF memory: blanking must still force black.
    drop_en(2, 1'b1);
    repeat (650) @(negedge clk);

    begin
      int guard = 0;
      while (!d_done && guard < 20000) begin
        @(negedge clk);
        guard++;
      end
      chk("full_timing_done", d_done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
